// File: rtl/data_memory_lsu.sv
// Byte-addressable little-endian data memory with RISC-V load/store sizes.
// Ports: req_* core load/store handshake, rsp_* registered response,
//   pre_* word preload handshake, init_done after post-reset clearing.
module data_memory_lsu #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_size,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  input  logic          pre_valid,
  output logic          pre_ready,
  input  logic [AW-1:0] pre_addr,
  input  logic [31:0]   pre_data,
  output logic          init_done
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IW    = $clog2(WORDS);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t        state;
  logic [IW-1:0] cnt;
  logic [31:0]   mem [WORDS];

  logic        req_fire;
  logic        pre_fire;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        is_u;
  logic        size_ok;
  logic [2:0]  nbytes;
  logic [AW:0] end_addr;
  logic        oob;
  logic        misalign;
  logic        err;
  logic        st_en;

  logic [1:0]    lane;
  logic [IW-1:0] ridx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ld;
  logic [3:0]    wmask;
  logic [31:0]   wdata_sh;

  logic [AW:0]   pre_end;
  logic          pre_ok;
  logic [IW-1:0] pidx;
  logic          unused_pre;

  assign pre_ready = (state == S_RUN);
  // preload wins a simultaneous request
  assign req_ready = (state == S_RUN) && !pre_valid;
  assign req_fire  = req_valid && req_ready;
  assign pre_fire  = pre_valid && pre_ready;

  assign is_b = (req_size[1:0] == 2'b00);
  assign is_h = (req_size[1:0] == 2'b01);
  assign is_w = (req_size == 3'b010);
  assign is_u = req_size[2];

  assign size_ok = (req_size == 3'b000)
                || (req_size == 3'b001)
                || (req_size == 3'b010)
                || (req_size == 3'b100)
                || (req_size == 3'b101);

  always_comb begin
    nbytes = 3'd1;
    unique case (1'b1)
      is_w:    nbytes = 3'd4;
      is_h:    nbytes = 3'd2;
      default: nbytes = 3'd1;
    endcase
  end

  // one extra bit so addresses near the top never wrap
  assign end_addr = {1'b0, req_addr}
                  + {{(AW-2){1'b0}}, nbytes};
  assign oob = end_addr > (AW+1)'(DEPTH_BYTES);

  assign misalign = (is_h && req_addr[0])
                 || (is_w && (req_addr[1:0] != 2'b00));

  assign err = !size_ok
            || (req_we && is_u)
            || misalign
            || oob;

  assign st_en = req_fire && req_we && !err;

  assign lane  = req_addr[1:0];
  assign ridx  = req_addr[IW+1:2];
  assign rword = mem[ridx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld = '0;
    unique case (1'b1)
      is_w: ld = rword;
      is_h: ld = is_u ? {16'h0, rhalf}
                      : {{16{rhalf[15]}}, rhalf};
      is_b: ld = is_u ? {24'h0, rbyte}
                      : {{24{rbyte[7]}}, rbyte};
      default: ld = '0;
    endcase
  end

  always_comb begin
    wmask = 4'b0001 << lane;
    unique case (1'b1)
      is_w:    wmask = 4'b1111;
      is_h:    wmask = 4'b0011 << lane;
      default: wmask = 4'b0001 << lane;
    endcase
  end

  assign wdata_sh = req_wdata << {lane, 3'b000};

  assign pre_end = {1'b0, pre_addr[AW-1:2], 2'b00}
                 + (AW+1)'(4);
  assign pre_ok  = pre_end <= (AW+1)'(DEPTH_BYTES);
  assign pidx    = pre_addr[IW+1:2];

  // low preload address bits select nothing: word granular
  assign unused_pre = ^pre_addr[1:0];

  // storage carries no reset; INIT sweeps it to zero
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (pre_fire && pre_ok) begin
      mem[pidx] <= pre_data;
    end else if (st_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) begin
          mem[ridx][8*k +: 8] <= wdata_sh[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_fire;
      rsp_err   <= req_fire && err;
      rsp_rdata <= (req_fire && !err && !req_we)
                 ? ld : '0;
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state     <= S_RUN;
          init_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: directed steps plus random
// requests against a byte-array reference model.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        pre_valid;
  logic        pre_ready;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;
  logic        init_done;

  always #5 clk = ~clk;

  data_memory_lsu #(
    .DEPTH_BYTES(1024),
    .AW(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .pre_valid(pre_valid),
    .pre_ready(pre_ready),
    .pre_addr(pre_addr),
    .pre_data(pre_data),
    .init_done(init_done)
  );

  logic [7:0] ref_mem [1024];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endfunction

  // reference: size rules in plain arithmetic over a byte array
  function automatic void model_req(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        err,
    output logic [31:0] rdata);
    int     nb;
    longint a;
    longint v;
    a = {32'h0, addr};
    err = 1'b0;
    rdata = '0;
    case (size)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default: begin nb = 1; err = 1'b1; end
    endcase
    if (we && size >= 3'd4) err = 1'b1;
    if ((a % nb) != 0) err = 1'b1;
    if (a + nb > 1024) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++)
        ref_mem[int'(a) + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++)
        v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
      if (size == 3'd0 && v >= 128) v = v - 256;
      if (size == 3'd1 && v >= 32768) v = v - 65536;
      rdata = 32'(v);
    end
  endfunction

  function automatic void model_pre(input logic [31:0] addr,
                                    input logic [31:0] data);
    longint base;
    base = {32'h0, addr & 32'hFFFF_FFFC};
    if (base + 4 <= 1024)
      for (int i = 0; i < 4; i++)
        ref_mem[int'(base) + i] = 8'(data >> (8 * i));
  endfunction

  // called at a negedge, returns at the negedge showing the response
  task automatic do_req(input logic        we,
                        input logic [2:0]  size,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input string       tag);
    logic        e;
    logic [31:0] r;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    model_req(we, size, addr, wdata, e, r);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check({tag, ":valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ":err"}, 32'(rsp_err), 32'(e));
    check({tag, ":rdata"}, rsp_rdata, r);
  endtask

  task automatic do_pre(input logic [31:0] addr,
                        input logic [31:0] data,
                        input string       tag);
    pre_valid = 1'b1;
    pre_addr  = addr;
    pre_data  = data;
    #1;
    check({tag, ":pready"}, 32'(pre_ready), 32'd1);
    model_pre(addr, data);
    @(posedge clk);
    #1 pre_valid = 1'b0;
    @(negedge clk);
    check({tag, ":norsp"}, 32'(rsp_valid), 32'd0);
  endtask

  // entered right after rst rises on a negedge
  task automatic wait_init(input string tag);
    int   n;
    logic early;
    n = 0;
    early = 1'b0;
    #1;
    while (!init_done && n < 2000) begin
      if (req_ready || pre_ready) early = 1'b1;
      n++;
      @(negedge clk);
    end
    check({tag, ":len"}, 32'(n), 32'd256);
    check({tag, ":blocked"}, 32'(early), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7) return 32'($urandom_range(0, 63));
    if (sel == 7) return 32'($urandom_range(1016, 1030));
    if (sel == 8) return 32'($urandom);
    return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [2:0] rand_size();
    int s;
    s = $urandom_range(0, 19);
    if (s < 4) return 3'd0;
    if (s < 8) return 3'd1;
    if (s < 12) return 3'd2;
    if (s < 15) return 3'd4;
    if (s < 18) return 3'd5;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'd0;
    req_addr  = '0;
    req_wdata = '0;
    pre_valid = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    clear_model();

    repeat (3) @(negedge clk);
    check("rst:req_ready", 32'(req_ready), 32'd0);
    check("rst:pre_ready", 32'(pre_ready), 32'd0);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rsp_err", 32'(rsp_err), 32'd0);
    check("rst:rsp_rdata", rsp_rdata, 32'd0);
    check("rst:init_done", 32'(init_done), 32'd0);

    // load held pending across the whole clear
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'd2;
    req_addr  = 32'h0;
    rst       = 1'b1;
    wait_init("init1");
    do_req(1'b0, 3'd2, 32'h0, 32'h0, "lw0");
    check("lw0:lit", rsp_rdata, 32'h0);

    do_pre(32'h10, 32'h80FF7F01, "pre10");
    do_req(1'b0, 3'd0, 32'h10, 0, "lb10");
    check("lb10:lit", rsp_rdata, 32'h00000001);
    do_req(1'b0, 3'd0, 32'h12, 0, "lb12");
    check("lb12:lit", rsp_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 3'd4, 32'h12, 0, "lbu12");
    check("lbu12:lit", rsp_rdata, 32'h000000FF);
    do_req(1'b0, 3'd1, 32'h12, 0, "lh12");
    check("lh12:lit", rsp_rdata, 32'hFFFF80FF);
    do_req(1'b0, 3'd5, 32'h12, 0, "lhu12");
    check("lhu12:lit", rsp_rdata, 32'h000080FF);
    do_req(1'b0, 3'd2, 32'h10, 0, "lw10");
    check("lw10:lit", rsp_rdata, 32'h80FF7F01);

    do_req(1'b1, 3'd0, 32'h21, 32'h000000AB, "sb21");
    do_req(1'b0, 3'd2, 32'h20, 0, "lw20a");
    check("lw20a:lit", rsp_rdata, 32'h0000AB00);
    do_req(1'b1, 3'd1, 32'h22, 32'h00001234, "sh22");
    do_req(1'b0, 3'd2, 32'h20, 0, "lw20b");
    check("lw20b:lit", rsp_rdata, 32'h1234AB00);

    do_pre(32'h3FC, 32'hCAFEF00D, "pre3fc");
    do_req(1'b0, 3'd2, 32'h002, 0, "e_lw2");
    check("e_lw2:lit", 32'(rsp_err), 32'd1);
    do_req(1'b0, 3'd1, 32'h003, 0, "e_lh3");
    check("e_lh3:lit", 32'(rsp_err), 32'd1);
    do_req(1'b1, 3'd2, 32'h3FE, 32'hFFFFFFFF, "e_sw3fe");
    check("e_sw3fe:lit", 32'(rsp_err), 32'd1);
    do_req(1'b0, 3'd2, 32'h400, 0, "e_lw400");
    check("e_lw400:lit", 32'(rsp_err), 32'd1);
    do_req(1'b0, 3'd3, 32'h10, 0, "e_sz3");
    check("e_sz3:lit", 32'(rsp_err), 32'd1);
    do_req(1'b1, 3'd4, 32'h10, 32'h55, "e_sbu");
    check("e_sbu:lit", 32'(rsp_err), 32'd1);
    do_req(1'b0, 3'd2, 32'h3FC, 0, "keep3fc");
    check("keep3fc:lit", rsp_rdata, 32'hCAFEF00D);
    do_req(1'b0, 3'd2, 32'h10, 0, "keep10");
    check("keep10:lit", rsp_rdata, 32'h80FF7F01);
    do_req(1'b0, 3'd2, 32'h0, 0, "keep0");
    check("keep0:lit", rsp_rdata, 32'h0);
    @(negedge clk);
    check("idle:rsp_valid", 32'(rsp_valid), 32'd0);

    // simultaneous preload and load
    pre_valid = 1'b1;
    pre_addr  = 32'h30;
    pre_data  = 32'h11223344;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'd2;
    req_addr  = 32'h30;
    #1;
    check("both:req_ready", 32'(req_ready), 32'd0);
    check("both:pre_ready", 32'(pre_ready), 32'd1);
    model_pre(32'h30, 32'h11223344);
    @(posedge clk);
    #1 pre_valid = 1'b0;
    @(negedge clk);
    check("both:norsp", 32'(rsp_valid), 32'd0);
    check("both:req_ready2", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("both:valid", 32'(rsp_valid), 32'd1);
    check("both:err", 32'(rsp_err), 32'd0);
    check("both:rdata", rsp_rdata, 32'h11223344);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 4) == 0)
        do_pre(rand_addr(), $urandom, "rpre");
      else
        do_req($urandom_range(0, 2) == 0, rand_size(),
               rand_addr(), $urandom, "rreq");
    end

    // reset landing in a response cycle
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'd2;
    req_addr  = 32'h10;
    #1;
    check("rr:ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
    check("rr:pulse", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rr:drop", 32'(rsp_valid), 32'd0);
    check("rr:init_done", 32'(init_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    wait_init("init2");
    do_req(1'b0, 3'd2, 32'h10, 0, "post10");
    check("post10:lit", rsp_rdata, 32'h0);
    do_req(1'b0, 3'd2, 32'h30, 0, "post30");
    check("post30:lit", rsp_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor to the single-cycle byte-addressable data memory.
- Little-endian byte array with RISC-V load/store sizes (byte, half, word), sign and zero extension, and a registered read with 1-cycle latency.
- Uses valid/ready request and preload handshakes and clears itself after reset.
- Sits between the core's memory stage and the testbench/loader preload path.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4, minimum 8.
AW, 32, width of address ports.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  core request accepted when valid&ready
req_we  in  1  1=store, 0=load
req_size  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  AW  byte address
req_wdata  in  32  store data, low bytes used per size
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extended
rsp_err  out  1  request rejected
pre_valid  in  1  preload word valid
pre_ready  out  1  preload accepted when valid&ready
pre_addr  in  AW  preload byte address, bits [1:0] ignored
pre_data  in  32  preload word, little-endian
init_done  out  1  high once clearing has finished

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to INIT and the clear counter goes to 0.
  - req_ready, pre_ready, rsp_valid, rsp_err and init_done go to 0; rsp_rdata goes to 0.
  - Any in-flight response is dropped.
  - Memory contents are not reset directly; INIT clears them.
- INIT:
  - Writes zero to word index cnt each cycle, cnt from 0 to DEPTH_BYTES/4-1.
  - req_ready=0 and pre_ready=0 throughout.
  - After the last word, the next state is RUN and init_done=1.
  - Duration is exactly DEPTH_BYTES/4 cycles after rst deasserts.
  - Reset asserted during INIT restarts clearing at cnt 0.
- RUN: init_done=1 and pre_ready=1.
  - req_ready = !pre_valid, so preload has priority on a simultaneous request.
  - Preload accept: writes 4 bytes at {pre_addr[AW-1:2],2'b00}. If out of range, the word is dropped silently and the handshake still completes. No response is produced.
  - Request accept: checks run in the same cycle. rsp_err=1 when any of these holds:
    - size is illegal (011, 110, 111);
    - req_we=1 with size 100 or 101;
    - half access with addr[0]=1;
    - word access with addr[1:0]!=0;
    - addr + bytes > DEPTH_BYTES, evaluated in AW+1 bits so there is no wrap-around.
  - Error case: no memory write; the next cycle has rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Store OK: bytes are written on the accepting edge (byte=addr, half=addr..addr+1, word=addr..addr+3, LSB at lowest address). The next cycle has rsp_valid=1, rsp_err=0, rsp_rdata=0.
  - Load OK: memory is read at the accepting edge. The next cycle has rsp_valid=1 and rsp_rdata:
    - b: byte sign-extended;
    - bu: byte zero-extended;
    - h: half sign-extended;
    - hu: half zero-extended;
    - w: full word.
  - rsp_valid deasserts the cycle after the pulse unless another request was accepted.
  - Back-to-back requests give one response per cycle.
- Ordering:
  - A load accepted the cycle after a store to overlapping bytes returns the new data.
  - A preload and a load never accept in the same cycle.
- Outputs are registered. rsp_* do not depend combinationally on req_*.

Test Plan:
- Release rst, hold req_valid=1 with a load-word at 0x0 → req_ready=0 and init_done=0 for 256 cycles (DEPTH 1024); then accept, rsp_valid one cycle later, rsp_rdata=0x00000000.
- Preload 0x80FF7F01 at 0x10, then loads at 0x10: lb → 0x00000001; lb at 0x12 → 0xFFFFFFFF; lbu at 0x12 → 0x000000FF; lh at 0x12 → 0xFFFF80FF; hu at 0x12 → 0x000080FF; lw → 0x80FF7F01.
- sb 0xAB at 0x21, then lw at 0x20 on the next cycle → 0x0000AB00, rsp_err=0; sh 0x1234 at 0x22, then lw 0x20 → 0x1234AB00.
- Each of these gives rsp_err=1, rsp_rdata=0 and leaves memory unchanged:
  - lw at 0x02;
  - lh at 0x03;
  - sw at 0x3FE;
  - lw at 0x3FC+4;
  - size 011;
  - store with size 100.
- pre_valid and req_valid together in RUN → preload accepted, req_ready=0 that cycle, request accepted next cycle with the correct response.
- Assert rst for 1 cycle during a load's response cycle → rsp_valid=0 immediately, init_done=0, memory cleared again (lw of the previously preloaded 0x10 returns 0 after re-init).
